// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the core writeback path has priority, while a small
// FIFO buffers the multi-cycle unit's results and is force-granted after a starvation limit.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          p_valid,
  output logic                          p_ready,
  input  logic [4:0]                    p_rd,
  input  logic [DATA_W-1:0]             p_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [4:0]                    s_rd,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd,
  output logic [DATA_W-1:0]             rf_wd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       LIMIT_C = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         starve_q, starve_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]  rf_wd_q, rf_wd_d;

  logic   empty, full, push, pop, p_grant;
  entry_t head;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign head  = fifo_mem[rd_ptr_q];

  // The FIFO wins when the core is idle or the starvation limit has been reached.
  assign pop     = !empty && (!p_valid || (starve_q == LIMIT_C));
  assign p_grant = p_valid && !pop;
  assign push    = s_valid && s_ready;

  assign p_ready = !rst && !pop;
  assign s_ready = !rst && !full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_wd_d  = rf_wd_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop || empty) begin
      starve_d = '0;
    end else if (p_grant && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + 4'd1;
    end

    // rd=0 requests are consumed and latched, but never raise the write enable.
    if (pop) begin
      rf_rd_d = head.rd;
      rf_wd_d = head.data;
      rf_we_d = (head.rd != 5'd0);
    end else if (p_grant) begin
      rf_rd_d = p_rd;
      rf_wd_d = p_data;
      rf_we_d = (p_rd != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{rd: s_rd, data: s_data};
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wd      = rf_wd_q;
  assign fifo_count = count_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
- Primary source: the core writeback path, fed by the writeback-mux output.
- Secondary source: a multi-cycle unit (late load return, MUL/DIV), buffered in a small FIFO.
- Fixed priority to primary, with a starvation limit that forces a secondary grant; write-port outputs are registered.

Parameters:
- DATA_W, 32, writeback data width.
- FIFO_DEPTH, 2, secondary buffer entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive primary grants allowed while FIFO non-empty before the FIFO is forced (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- p_valid  input  1  primary writeback request.
- p_ready  output  1  primary accepted this cycle (core stalls when p_valid & !p_ready).
- p_rd  input  5  primary destination register.
- p_data  input  DATA_W  primary write data.
- s_valid  input  1  secondary writeback request.
- s_ready  output  1  secondary accepted into FIFO this cycle.
- s_rd  input  5  secondary destination register.
- s_data  input  DATA_W  secondary write data.
- rf_we  output  1  register-file write enable (registered).
- rf_rd  output  5  register-file write address (registered).
- rf_wd  output  DATA_W  register-file write data (registered).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset: async clear of FIFO pointers, fifo_count, starve_cnt, rf_we, rf_rd and rf_wd (all 0). p_ready=0 and s_ready=0 while rst=1.
- s_ready = !full. A transfer occurs on s_valid & s_ready and pushes {s_rd, s_data} at the clock edge.
- No bypass: a pushed entry is eligible for grant no earlier than the next cycle.
- Grant, evaluated combinationally each cycle:
  - FIFO non-empty and (!p_valid or starve_cnt==STARVE_LIMIT): grant FIFO head (pop); p_ready=0.
  - Otherwise, if p_valid: grant primary; p_ready=1.
  - Otherwise: no grant; p_ready=1 (idle-ready).
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when primary is granted while the FIFO is non-empty.
  - Clears on a FIFO grant or when the FIFO is empty.
- Output register, updated at the edge after a grant:
  - rf_rd and rf_wd take the granted entry.
  - rf_we = 1 only if the granted rd != 0.
  - With no grant, rf_we=0 and rf_rd/rf_wd hold their last values.
- x0: a rd=0 request is still consumed (handshake completes, pop occurs) but produces rf_we=0.
- Latency:
  - Primary accepted in cycle N: rf_we in cycle N+1.
  - Secondary pushed in cycle N: earliest rf_we in cycle N+2.
- Push and pop in the same cycle: fifo_count is unchanged and entries stay in FIFO order.
- Full FIFO with a pop in the same cycle: s_ready is still 0 (based on registered full, no pass-through).
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never underflows; pop is only possible when non-empty.
- Ordering hazards between the primary and secondary sources on the same rd are not resolved here. The issue logic guarantees they do not occur.
- Reset asserted mid-operation discards buffered entries; no write is issued for them after reset release.

Test Plan:
1. Primary only. Cycle 0: p_valid=1, p_rd=5, p_data=AAAAAAAA; s_valid=0 -> p_ready=1; cycle 1: rf_we=1, rf_rd=5, rf_wd=AAAAAAAA; cycle 2: rf_we=0.
2. Secondary only. Cycle 0: s_valid=1, s_rd=7, s_data=BBBBBBBB; p_valid=0 -> s_ready=1, fifo_count=1 at cycle 1; cycle 2: rf_we=1, rf_rd=7, rf_wd=BBBBBBBB; fifo_count=0.
3. Starvation, STARVE_LIMIT=4. p_valid=1 continuously (rd=1, distinct data per cycle); one s push in cycle 0 (rd=9, data=12345000) -> primary granted cycles 0-4; cycle 5: p_ready=0 and FIFO granted; cycle 6: rf_rd=9, rf_wd=12345000; cycle 6 primary granted again with starve_cnt=0.
4. FIFO full. p_valid held 1; s pushes in cycles 0 and 1 -> fifo_count=2 and s_ready=0 from cycle 2 until the first forced pop; s_ready returns to 1 the cycle after the pop.
5. x0 write. p_valid=1, p_rd=0, p_data=FFFFFFFF -> p_ready=1; next cycle rf_we=0. Same for s_rd=0: entry popped, fifo_count decrements, rf_we=0.
6. Async reset. Two entries buffered; assert rst between clock edges -> fifo_count, rf_we, p_ready and s_ready go to 0 immediately. After release with no requests, rf_we stays 0 for 5 cycles.
